seq_div_unit: RTL

Parametrised multi-cycle integer divider for the ALU datapath. It replaces the purely combinational 32-bit restoring divider with a clocked iterative engine that has a start/done handshake, selectable signed or unsigned mode, configurable width and bits retired per cycle, and defined divide-by-zero and overflow results. The control unit starts it on DIV and stalls on busy. The result packs into RZ as {remainder, quotient}, matching the existing HI/LO writeback.

---
 rtl/seq_div_unit_if.sv | 27 ++
 rtl/seq_div_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/seq_div_unit_if.sv
// Divider request/result bundle between the ALU control unit and seq_div_unit.
// The control unit side is master; the divider side is slave.
// RZ packs {remainder, quotient}.
interface seq_div_unit_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               abort;
  logic               is_signed;
  logic [WIDTH-1:0]   RA;
  logic [WIDTH-1:0]   RB;
  logic               busy;
  logic               done;
  logic               div_zero;
  logic               overflow;
  logic [2*WIDTH-1:0] RZ;

  modport master (
    output start, abort, is_signed, RA, RB,
    input  busy, done, div_zero, overflow, RZ
  );

  modport slave (
    input  start, abort, is_signed, RA, RB,
    output busy, done, div_zero, overflow, RZ
  );
endinterface

// File: rtl/seq_div_unit.sv
// Iterative restoring divider, BPC quotient bits per cycle, signed/unsigned.
// Latency: done rises WIDTH/BPC+1 edges after the start edge; start ignored while busy.
// Optional SEQ_DIV_FAST_ZERO_EN: zero divisor skips the iteration and completes next edge.
module seq_div_unit #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input logic          clk,
  input logic          rst_n,
  seq_div_unit_if.slave bus
);

  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               a_neg;
  logic               b_neg;
  logic               zero_div;
  logic               ovf_case;
  logic [WIDTH-1:0]   ra_raw;
  logic [WIDTH-1:0]   mb;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] rz_q;
  logic               done_q;
  logic               dz_q;
  logic               ov_q;

  logic [WIDTH-1:0]   ma_in;
  logic [WIDTH-1:0]   mb_in;
  logic [WIDTH-1:0]   quo_step;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH:0]     sh;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    ma_in = (bus.is_signed && bus.RA[WIDTH-1]) ? -bus.RA : bus.RA;
    mb_in = (bus.is_signed && bus.RB[WIDTH-1]) ? -bus.RB : bus.RB;
  end

  // BPC restoring steps; the shifted partial remainder is WIDTH+1 bits, and
  // after a subtract it always fits back into WIDTH bits because rem < mb.
  always_comb begin
    rem_step = rem;
    quo_step = quo;
    sh       = '0;
    for (int i = 0; i < BPC; i++) begin
      sh       = {rem_step, quo_step[WIDTH-1]};
      quo_step = {quo_step[WIDTH-2:0], 1'b0};
      if (sh >= {1'b0, mb}) begin
        rem_step    = WIDTH'(sh - {1'b0, mb});
        quo_step[0] = 1'b1;
      end else begin
        rem_step = sh[WIDTH-1:0];
      end
    end
  end

  // Sign correction and divide-by-zero override; MIN / -1 falls out naturally
  // as quotient MIN, remainder 0.
  always_comb begin
    quo_fix = (a_neg ^ b_neg) ? -quo : quo;
    rem_fix = a_neg ? -rem : rem;
    if (zero_div) begin
      quo_fix = '1;
      rem_fix = ra_raw;
    end
  end

  // Control FSM and datapath registers; abort wins over start and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      zero_div <= 1'b0;
      ovf_case <= 1'b0;
      ra_raw   <= '0;
      mb       <= '0;
      quo      <= '0;
      rem      <= '0;
      rz_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              a_neg    <= bus.is_signed & bus.RA[WIDTH-1];
              b_neg    <= bus.is_signed & bus.RB[WIDTH-1];
              zero_div <= (bus.RB == '0);
              ovf_case <= bus.is_signed && (bus.RA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                          (bus.RB == '1);
              ra_raw   <= bus.RA;
              mb       <= mb_in;
              quo      <= ma_in;
              rem      <= '0;
              cnt      <= CW'(STEPS);
`ifdef SEQ_DIV_FAST_ZERO_EN
              state    <= (bus.RB == '0) ? S_FIX : S_ITER;
`else
              state    <= S_ITER;
`endif
            end
          end
          S_ITER: begin
            quo <= quo_step;
            rem <= rem_step;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state <= S_FIX;
            end
          end
          S_FIX: begin
            rz_q   <= {rem_fix, quo_fix};
            dz_q   <= zero_div;
            ov_q   <= ovf_case & ~zero_div;
            done_q <= 1'b1;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_q;
  assign bus.RZ       = rz_q;
  assign bus.div_zero = dz_q;
  assign bus.overflow = ov_q;

endmodule
